// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/div with a fixed
// busy latency and raises m_stall for HI/LO-dependent instructions in D.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_uses_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        m_stall
);
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    logic [3:0]  cnt;
    logic [31:0] pend_hi_p1;
    logic [31:0] pend_lo_p1;
    logic        pend_wr_p1;
    logic [63:0] md_result_p0;

    function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return p;
    endfunction

    // Divide on magnitudes so that 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb, q, r;
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q  = (mb == 32'd0) ? 32'd0 : ma / mb;
        r  = (mb == 32'd0) ? 32'd0 : ma % mb;
        if (a[31] ^ b[31]) q = -q;
        if (a[31]) r = -r;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 64'd0;
        return {a % b, a / b};
    endfunction

    always_comb begin
        md_result_p0 = 64'd0;
        case (md_op)
            OP_MULT:  md_result_p0 = mul_signed(rs_val, rt_val);
            OP_MULTU: md_result_p0 = {32'd0, rs_val} * {32'd0, rt_val};
            OP_DIV:   md_result_p0 = div_signed(rs_val, rt_val);
            OP_DIVU:  md_result_p0 = div_unsigned(rs_val, rt_val);
            default:  md_result_p0 = 64'd0;
        endcase
    end

    // Stage boundary: operands are captured at acceptance, HI/LO written when the count expires.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi         <= 32'd0;
            lo         <= 32'd0;
            busy       <= 1'b0;
            cnt        <= 4'd0;
            pend_hi_p1 <= 32'd0;
            pend_lo_p1 <= 32'd0;
            pend_wr_p1 <= 1'b0;
        end else if (!busy) begin
            if (start) begin
                case (md_op)
                    OP_MTHI: hi <= rs_val;
                    OP_MTLO: lo <= rs_val;
                    OP_MULT, OP_MULTU: begin
                        busy                     <= 1'b1;
                        cnt                      <= MULT_LOAD;
                        {pend_hi_p1, pend_lo_p1} <= md_result_p0;
                        pend_wr_p1               <= 1'b1;
                    end
                    OP_DIV, OP_DIVU: begin
                        busy                     <= 1'b1;
                        cnt                      <= DIV_LOAD;
                        {pend_hi_p1, pend_lo_p1} <= md_result_p0;
                        pend_wr_p1               <= (rt_val != 32'd0);
                    end
                    default: ;
                endcase
            end
        end else if (cnt == 4'd0) begin
            busy <= 1'b0;
            if (pend_wr_p1) begin
                hi <= pend_hi_p1;
                lo <= pend_lo_p1;
            end
        end else begin
            cnt <= cnt - 4'd1;
        end
    end

    assign m_stall = d_uses_md & (busy | start);

endmodule
